// File: rtl/log_div_lut_loader.sv
// Front-end for the log-scale float16 divider: streams LUT_SIZE init beats into the divider's
// LUT write port, then admits operand pairs and returns each quotient after the fixed latency.
module log_div_lut_loader #(
    parameter int FLOAT_LEN   = 16,
    parameter int MANT_LEN    = 10,
    parameter int LUT_SIZE    = 128,
    parameter int DIV_LATENCY = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cfg_valid,
    output logic                                   cfg_ready,
    input  logic [MANT_LEN-1:0]                    cfg_log2,
    input  logic [FLOAT_LEN-1:0]                   cfg_exp2,
    output logic                                   lut_wr_en,
    output logic [MANT_LEN-1:0]                    log2_lut_data,
    output logic [FLOAT_LEN-1:0]                   exp2_lut_data,
    output logic                                   lut_done,
    input  logic                                   op_valid,
    output logic                                   op_ready,
    input  logic [FLOAT_LEN-1:0]                   op_a,
    input  logic [FLOAT_LEN-1:0]                   op_b,
    output logic [FLOAT_LEN-1:0]                   div_a,
    output logic [FLOAT_LEN-1:0]                   div_b,
    input  logic [FLOAT_LEN-1:0]                   div_result,
    output logic                                   res_valid,
    output logic [FLOAT_LEN-1:0]                   res_data,
    output logic [$clog2(DIV_LATENCY+2)-1:0]       in_flight,
    output logic                                   dbg_state
);

    localparam int CNT_W = $clog2(LUT_SIZE + 1);
    localparam int IF_W  = $clog2(DIV_LATENCY + 2);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [DIV_LATENCY:0] vpipe;
    logic                 cfg_accept;
    logic                 op_accept;
    logic                 res_edge;

    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // ready depends only on state (never on valid), and the host holds valid/data until then.
    assign cfg_accept = cfg_valid && cfg_ready;
    assign op_accept  = op_valid && op_ready;
    assign res_edge   = vpipe[DIV_LATENCY];
    assign dbg_state  = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        cfg_ready  = 1'b0;
        op_ready   = 1'b0;
        case (state)
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (cnt == CNT_W'(LUT_SIZE - 1))) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // Only reset leaves RUN: the divider's LUT write pointer cannot rewind.
                op_ready = 1'b1;
            end
            default: next_state = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            lut_wr_en     <= 1'b0;
            log2_lut_data <= '0;
            exp2_lut_data <= '0;
            lut_done      <= 1'b0;
        end else begin
            lut_wr_en <= cfg_accept;
            if (cfg_accept) begin
                log2_lut_data <= cfg_log2;
                exp2_lut_data <= cfg_exp2;
                cnt           <= cnt + CNT_W'(1);
            end
            // Rises together with the final write strobe.
            if (next_state == RUN) begin
                lut_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_a     <= '0;
            div_b     <= '0;
            vpipe     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            in_flight <= '0;
        end else begin
            if (op_accept) begin
                div_a <= op_a;
                div_b <= op_b;
            end
            // vpipe[DIV_LATENCY] marks the edge where div_result reflects that op.
            vpipe     <= {vpipe[DIV_LATENCY-1:0], op_accept};
            res_valid <= res_edge;
            if (res_edge) begin
                res_data <= div_result;
            end
            case ({op_accept, res_edge})
                2'b10:   in_flight <= in_flight + IF_W'(1);
                2'b01:   in_flight <= in_flight - IF_W'(1);
                default: in_flight <= in_flight;
            endcase
        end
    end

endmodule
